// File: rtl/muldiv_if.sv
// Operand/request and write-back bundle between the register file and the mul/div unit.
interface muldiv_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 3
);
  logic                  start;
  logic [1:0]            op;
  logic [WIDTH-1:0]      a;
  logic [WIDTH-1:0]      b;
  logic [ADDR_WIDTH-1:0] dest;
  logic                  busy;
  logic                  done;
  logic [WIDTH-1:0]      result;
  logic [ADDR_WIDTH-1:0] wr_num;
  logic                  wr_en;
  logic                  div_zero;

  modport master (
    output start, op, a, b, dest,
    input  busy, done, result, wr_num, wr_en, div_zero
  );

  modport slave (
    input  start, op, a, b, dest,
    output busy, done, result, wr_num, wr_en, div_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit: shift-add multiply, restoring divide,
// one bit per clock, single-cycle write-back pulse on completion.
module muldiv_unit #(
  parameter int WIDTH      = 16,
  parameter int SIZE       = 8,
  parameter int ADDR_WIDTH = $clog2(SIZE)
) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [1:0]            op_r;
  logic [WIDTH-1:0]      opnd;
  logic [WIDTH-1:0]      acc_hi;
  logic [WIDTH-1:0]      acc_lo;
  logic [2*WIDTH-1:0]    step;
  logic                  busy_r;
  logic                  done_r;
  logic                  dz_r;
  logic [WIDTH-1:0]      result_r;
  logic [ADDR_WIDTH-1:0] wr_num_r;

  // acc_hi holds the partial product high half; acc_lo the multiplier, shifted out LSB first.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [WIDTH-1:0] hi,
                                                  input logic [WIDTH-1:0] lo,
                                                  input logic [WIDTH-1:0] m);
    logic [WIDTH:0] sum;
    sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    return {sum, lo[WIDTH-1:1]};
  endfunction

  // acc_hi holds the partial remainder; acc_lo shifts the dividend out and quotient bits in.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] hi,
                                                  input logic [WIDTH-1:0] lo,
                                                  input logic [WIDTH-1:0] d);
    logic [WIDTH:0] sh;
    logic           ge;
    sh = {hi, lo[WIDTH-1]};
    ge = (sh >= {1'b0, d});
    if (ge) sh = sh - {1'b0, d};
    return {sh[WIDTH-1:0], lo[WIDTH-2:0], ge};
  endfunction

  always_comb begin
    step = op_r[1] ? div_step(acc_hi, acc_lo, opnd) : mul_step(acc_hi, acc_lo, opnd);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op_r     <= '0;
      opnd     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      dz_r     <= 1'b0;
      result_r <= '0;
      wr_num_r <= '0;
    end else begin
      case (state)
        RUN: begin
          acc_hi <= step[2*WIDTH-1:WIDTH];
          acc_lo <= step[WIDTH-1:0];
          cnt    <= cnt - 1'b1;
          if (cnt == '0) begin
            state    <= DONE;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            // op[0] picks the high half / remainder, which both live in acc_hi.
            result_r <= op_r[0] ? step[2*WIDTH-1:WIDTH] : step[WIDTH-1:0];
          end
        end
        default: begin
          done_r <= 1'b0;
          state  <= IDLE;
          if (bus.start) begin
            op_r     <= bus.op;
            opnd     <= bus.op[1] ? bus.b : bus.a;
            acc_hi   <= '0;
            acc_lo   <= bus.op[1] ? bus.a : bus.b;
            wr_num_r <= bus.dest;
            cnt      <= CNT_W'(WIDTH - 1);
            if (bus.op[1] && (bus.b == '0)) begin
              state    <= DONE;
              done_r   <= 1'b1;
              dz_r     <= 1'b1;
              result_r <= bus.op[0] ? bus.a : '1;
            end else begin
              state  <= RUN;
              busy_r <= 1'b1;
              dz_r   <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.wr_en    = done_r;
  assign bus.result   = result_r;
  assign bus.wr_num   = wr_num_r;
  assign bus.div_zero = dz_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, multi-cycle corner sequences and
// randomized operations against an arithmetic reference model.
module tb_muldiv_unit;
  localparam int W  = 16;
  localparam int AW = 3;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  muldiv_if #(.WIDTH(W), .ADDR_WIDTH(AW)) m();

  muldiv_unit #(.WIDTH(W), .SIZE(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (m.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [1:0]    op;
    logic [AW-1:0] dest;
    logic [W-1:0]  res;
    logic          dz;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] op, input logic [AW-1:0] dest);
    @(negedge clk);
    m.start = 1'b1; m.a = a; m.b = b; m.op = op; m.dest = dest;
    @(posedge clk);
    #1;
    m.start = 1'b0;
    m.a = 16'($urandom); m.b = 16'($urandom); m.op = 2'($urandom); m.dest = 3'($urandom);
  endtask

  // Counts cycles after the accept edge until done; flags busy&done overlap or wr_en != done.
  task automatic wait_done(output int lat, output int bcnt, output logic bad);
    lat = 0; bcnt = 0; bad = 1'b0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (m.busy) bcnt++;
      if ((m.busy && m.done) || (m.wr_en !== m.done)) bad = 1'b1;
      if (m.done) break;
    end
  endtask

  task automatic check_done(input string name, input logic [W-1:0] res, input logic [AW-1:0] dest,
                            input logic dz, input int lat, input int bcnt, input logic bad);
    check({name, " result"}, 32'(m.result), 32'(res));
    check({name, " wr_num"}, 32'(m.wr_num), 32'(dest));
    check({name, " div_zero"}, 32'(m.div_zero), 32'(dz));
    check({name, " latency"}, 32'(lat), dz ? 32'd1 : 32'(W + 1));
    check({name, " busy_cycles"}, 32'(bcnt), dz ? 32'd0 : 32'(W));
    check({name, " strobe_overlap"}, 32'(bad), 32'd0);
  endtask

  task automatic run_and_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [1:0] op, input logic [AW-1:0] dest,
                               input logic [W-1:0] res, input logic dz);
    int   lat, bcnt;
    logic bad;
    launch(a, b, op, dest);
    wait_done(lat, bcnt, bad);
    check_done(name, res, dest, dz, lat, bcnt, bad);
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] op);
    logic [2*W-1:0] prod;
    prod = (2*W)'(a) * (2*W)'(b);
    case (op)
      2'b00:   return prod[W-1:0];
      2'b01:   return prod[2*W-1:W];
      2'b10:   return (b == '0) ? '1 : a / b;
      default: return (b == '0) ? a : a % b;
    endcase
  endfunction

  task automatic idle_watch(input string name, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (m.done || m.wr_en) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  initial begin
    int   lat, bcnt;
    logic bad;
    logic [W-1:0] ra, rb;
    logic [1:0]   rop;
    logic [AW-1:0] rd;

    checks = 0; errors = 0;
    tbl[0] = '{16'd300,  16'd250, 2'b00, 3'd3, 16'h24F8, 1'b0};
    tbl[1] = '{16'd300,  16'd250, 2'b01, 3'd4, 16'h0001, 1'b0};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 2'b00, 3'd5, 16'h0001, 1'b0};
    tbl[3] = '{16'hFFFF, 16'hFFFF, 2'b01, 3'd6, 16'hFFFE, 1'b0};
    tbl[4] = '{16'd1000, 16'd7,   2'b10, 3'd1, 16'd142,  1'b0};
    tbl[5] = '{16'd1000, 16'd7,   2'b11, 3'd2, 16'd6,    1'b0};
    tbl[6] = '{16'h1234, 16'd0,   2'b00, 3'd7, 16'h0000, 1'b0};
    tbl[7] = '{16'h1234, 16'd0,   2'b10, 3'd0, 16'hFFFF, 1'b1};
    tbl[8] = '{16'h1234, 16'd0,   2'b11, 3'd6, 16'h1234, 1'b1};

    reset = 1'b1;
    m.start = 1'b0; m.a = '0; m.b = '0; m.op = '0; m.dest = '0;
    #12;
    check("reset_outputs", {m.busy, m.done, m.wr_en, m.div_zero, m.wr_num, m.result},
          32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++)
      run_and_check($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].dest,
                    tbl[i].res, tbl[i].dz);

    // A MUL accepted after a divide-by-zero clears the sticky flag at once.
    launch(16'd300, 16'd250, 2'b00, 3'd3);
    check("dz_cleared_on_accept", 32'(m.div_zero), 32'd0);
    check("result_held_until_done", 32'(m.result), 32'h1234);
    wait_done(lat, bcnt, bad);
    check_done("mul_after_dz", 16'h24F8, 3'd3, 1'b0, lat, bcnt, bad);

    // start pulsed during RUN must be ignored.
    launch(16'd300, 16'd250, 2'b00, 3'd3);
    for (int i = 0; i < 5; i++) @(negedge clk);
    m.start = 1'b1; m.a = 16'd9; m.b = 16'd9; m.op = 2'b11; m.dest = 3'd7;
    @(posedge clk);
    #1 m.start = 1'b0;
    wait_done(lat, bcnt, bad);
    check_done("start_in_run", 16'h24F8, 3'd3, 1'b0, lat + 5, bcnt + 5, bad);
    idle_watch("no_extra_done", 20);

    // start held in the DONE cycle is accepted back-to-back.
    launch(16'd1000, 16'd7, 2'b10, 3'd2);
    wait_done(lat, bcnt, bad);
    check_done("b2b_first", 16'd142, 3'd2, 1'b0, lat, bcnt, bad);
    m.start = 1'b1; m.a = 16'd300; m.b = 16'd250; m.op = 2'b01; m.dest = 3'd5;
    @(posedge clk);
    #1 m.start = 1'b0;
    wait_done(lat, bcnt, bad);
    check_done("b2b_second", 16'h0001, 3'd5, 1'b0, lat, bcnt, bad);

    for (int i = 0; i < 60; i++) begin
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      rop = 2'($urandom);
      rd  = 3'($urandom);
      if (i % 10 == 3) rb = 16'($urandom_range(1, 15));
      run_and_check($sformatf("rand%0d", i), ra, rb, rop, rd, model(ra, rb, rop),
                    rop[1] && (rb == '0));
    end

    // Reset in the middle of a DIV: outputs clear immediately, no write-back follows.
    launch(16'd1000, 16'd7, 2'b11, 3'd6);
    for (int i = 0; i < 8; i++) @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_mid_op", {m.busy, m.done, m.wr_en, m.div_zero, m.wr_num, m.result}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle_watch("no_done_after_reset", 40);

    run_and_check("after_reset", 16'd1000, 16'd7, 2'b10, 3'd1, 16'd142, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
